hs_ready_slice: RTL and testbench

HS_READY_SLICE -- requirements
Module: hs_ready_slice

---
 rtl/hs_ready_slice_pkg.sv | 17 +
 rtl/hs_ready_slice.sv | 55 +++++
 tb/tb_hs_ready_slice.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hs_ready_slice_pkg.sv
// hs_ready_slice_pkg: handshake constants and the skid-stage state encoding shared by the hs blocks.
package hs_ready_slice_pkg;

    localparam logic HS_READY_IN_RESET = 1'b0;
    localparam logic HS_VALID_IN_RESET = 1'b0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(state_t s);
        return s == FULL ? 2'd2 : s == BUSY ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/hs_ready_slice.sv
// hs_ready_slice: two-entry skid stage with every output driven straight from a flop.
module hs_ready_slice
    import hs_ready_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rx_hs_ready,
    input  logic                  rx_hs_valid,
    input  logic [DATA_WIDTH-1:0] rx_hs_data,
    input  logic                  tx_hs_ready,
    output logic                  tx_hs_valid,
    output logic [DATA_WIDTH-1:0] tx_hs_data,
    output logic [1:0]            occupancy
);

    state_t                state, nxt;
    logic [DATA_WIDTH-1:0] main, skid;
    logic                  rx_x, tx_x;

    assign tx_hs_data = main;
    assign rx_x       = rx_hs_ready && rx_hs_valid;
    assign tx_x       = tx_hs_valid && tx_hs_ready;

    always_comb begin
        nxt = state == EMPTY ? (rx_x ? BUSY : EMPTY)
            : state == BUSY  ? (rx_x && !tx_x ? FULL : !rx_x && tx_x ? EMPTY : BUSY)
            : (tx_hs_ready ? BUSY : FULL);
    end

    // ready is 0 through reset and only rises on the first edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            rx_hs_ready <= HS_READY_IN_RESET;
            tx_hs_valid <= HS_VALID_IN_RESET;
            occupancy   <= 2'd0;
            main        <= '0;
            skid        <= '0;
        end else begin
            state       <= nxt;
            rx_hs_ready <= nxt != FULL;
            tx_hs_valid <= nxt != EMPTY;
            occupancy   <= occ_of(nxt);
            if (rx_x && (state == EMPTY || (state == BUSY && tx_x)))
                main <= rx_hs_data;
            else if (state == FULL && tx_hs_ready)
                main <= skid;
            if (rx_x && state == BUSY && !tx_x)
                skid <= rx_hs_data;
        end
    end

endmodule

// File: tb/tb_hs_ready_slice.sv
// tb_hs_ready_slice: directed and random-backpressure checks of the skid stage.
module tb_hs_ready_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_hs_ready;
    logic        rx_hs_valid = 1'b0;
    logic [63:0] rx_hs_data = '0;
    logic        tx_hs_ready = 1'b0;
    logic        tx_hs_valid;
    logic [63:0] tx_hs_data;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    hs_ready_slice dut (
        .clk        (clk),
        .rst        (rst),
        .rx_hs_ready(rx_hs_ready),
        .rx_hs_valid(rx_hs_valid),
        .rx_hs_data (rx_hs_data),
        .tx_hs_ready(tx_hs_ready),
        .tx_hs_valid(tx_hs_valid),
        .tx_hs_data (tx_hs_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic vld, input logic [1:0] occ);
        chk({tag, ".rx_ready"}, 64'(rx_hs_ready), 64'(rdy));
        chk({tag, ".tx_valid"}, 64'(tx_hs_valid), 64'(vld));
        chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
    endtask

    initial begin
        int sent, rcvd, cyc, comb_viol;
        logic [63:0] snap_d;
        logic [3:0]  snap_c;

        // reset and first word
        #2 rst = 1'b0;
        #1 chk_state("rst_async", 1'b0, 1'b0, 2'd0);
        repeat (3) step();
        chk_state("rst_hold", 1'b0, 1'b0, 2'd0);
        chk("rst_data", tx_hs_data, 64'h0);
        rst = 1'b1;
        #1 chk("rst_release_pre_edge", 64'(rx_hs_ready), 64'd0);
        step();
        chk_state("rst_first_edge", 1'b1, 1'b0, 2'd0);
        rx_hs_valid = 1'b1; rx_hs_data = 64'h11; tx_hs_ready = 1'b1;
        step();
        rx_hs_valid = 1'b0;
        chk_state("first_word", 1'b1, 1'b1, 2'd1);
        chk("first_word.data", tx_hs_data, 64'h11);
        step();
        chk_state("first_word_gone", 1'b1, 1'b0, 2'd0);

        // streaming
        for (int i = 1; i <= 8; i++) begin
            rx_hs_valid = 1'b1; rx_hs_data = 64'(i);
            step();
            chk("stream.data", tx_hs_data, 64'(i));
            chk_state("stream", 1'b1, 1'b1, 2'd1);
        end
        rx_hs_valid = 1'b0;
        step();
        chk_state("stream_end", 1'b1, 1'b0, 2'd0);

        // stall
        tx_hs_ready = 1'b0;
        rx_hs_valid = 1'b1; rx_hs_data = 64'hA;
        step();
        chk_state("stall_a", 1'b1, 1'b1, 2'd1);
        chk("stall_a.data", tx_hs_data, 64'hA);
        rx_hs_data = 64'hB;
        step();
        chk_state("stall_b", 1'b0, 1'b1, 2'd2);
        chk("stall_b.data", tx_hs_data, 64'hA);
        rx_hs_data = 64'hC;
        step();
        chk_state("stall_c", 1'b0, 1'b1, 2'd2);
        chk("stall_c.data", tx_hs_data, 64'hA);

        // drain with 0xC still offered
        tx_hs_ready = 1'b1;
        step();
        chk_state("drain_b", 1'b1, 1'b1, 2'd1);
        chk("drain_b.data", tx_hs_data, 64'hB);
        step();
        rx_hs_valid = 1'b0;
        chk_state("drain_c", 1'b1, 1'b1, 2'd1);
        chk("drain_c.data", tx_hs_data, 64'hC);
        step();
        chk_state("drain_end", 1'b1, 1'b0, 2'd0);

        // random backpressure, 10000 incrementing words
        sent = 0; rcvd = 0; cyc = 0; comb_viol = 0;
        while (rcvd < 10000 && cyc < 80000) begin
            snap_d = tx_hs_data;
            snap_c = {rx_hs_ready, tx_hs_valid, occupancy};
            rx_hs_valid = (sent < 10000) && $urandom_range(1, 0) == 1;
            rx_hs_data  = 64'(sent);
            tx_hs_ready = $urandom_range(1, 0) == 1;
            #1;
            if (tx_hs_data !== snap_d || {rx_hs_ready, tx_hs_valid, occupancy} !== snap_c)
                comb_viol++;
            if (rx_hs_valid && rx_hs_ready) sent++;
            if (tx_hs_valid && tx_hs_ready) begin
                chk("random.order", tx_hs_data, 64'(rcvd));
                rcvd++;
            end
            step();
            cyc++;
        end
        rx_hs_valid = 1'b0;
        chk("random.words_out", 64'(rcvd), 64'd10000);
        chk("random.comb_paths", 64'(comb_viol), 64'd0);

        // mid-operation reset while FULL
        repeat (3) step();
        tx_hs_ready = 1'b0;
        rx_hs_valid = 1'b1; rx_hs_data = 64'h1;
        step();
        rx_hs_data = 64'h2;
        step();
        rx_hs_valid = 1'b0;
        chk_state("pre_reset_full", 1'b0, 1'b1, 2'd2);
        #2 rst = 1'b0;
        #1 chk_state("mid_reset_async", 1'b0, 1'b0, 2'd0);
        step();
        rst = 1'b1;
        step();
        chk_state("mid_reset_release", 1'b1, 1'b0, 2'd0);
        rx_hs_valid = 1'b1; rx_hs_data = 64'h5;
        step();
        rx_hs_valid = 1'b0;
        chk_state("after_reset_word", 1'b1, 1'b1, 2'd1);
        chk("after_reset_word.data", tx_hs_data, 64'h5);
        tx_hs_ready = 1'b1;
        step();
        chk_state("after_reset_alone", 1'b1, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
